// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline registers: flag layout and the
// packed E-stage control bundle.
package arm_pipe_pkg;

  localparam int NFLAGS = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic [1:0] alucontrol;
    logic [1:0] flagwrite;
    logic [3:0] cond;
  } ctrl_t;

  // A bubble writes nothing, branches nowhere and never touches the flags.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/flopenrc.sv
// Enabled flip-flop with asynchronous active-low reset and synchronous clear.
// Clear only acts on an enabled edge, so a held value is never zeroed.
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear selects a constant, so unknown data on a clear edge never lands.
  assign q_d = clr_i ? '0 : d_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall/flush, plus the
// architectural NZCV flags register that reloads from the condition logic.
module id_ex_pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int NFLAGS = arm_pipe_pkg::NFLAGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ALUControlD,
  input  logic [1:0]        FlagWriteD,
  input  logic [3:0]        CondD,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3D,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  ExtImmD,
  input  logic [NFLAGS-1:0] FlagsNextE,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ALUControlE,
  output logic [1:0]        FlagWriteE,
  output logic [3:0]        CondE,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [3:0]        WA3E,
  output logic [WIDTH-1:0]  RD1E,
  output logic [WIDTH-1:0]  RD2E,
  output logic [WIDTH-1:0]  ExtImmE,
  output logic [NFLAGS-1:0] FlagsE,
  output logic              ValidE
);

  import arm_pipe_pkg::*;

  logic pipe_en;
  logic flags_en;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic [11:0]        addr_d;
  logic [11:0]        addr_q;
  logic [3*WIDTH-1:0] data_d;
  logic [3*WIDTH-1:0] data_q;

  // Flush beats stall: a flushed edge must still advance, loading the bubble.
  assign pipe_en = ~StallE | FlushE;
  // The instruction leaving E keeps its flag update even when E is flushed.
  assign flags_en = ~StallE | FlushE;

  assign ctrl_d = '{pcsrc: PCSrcD, regwrite: RegWriteD, memtoreg: MemtoRegD,
                    memwrite: MemWriteD, branch: BranchD, alusrc: ALUSrcD,
                    alucontrol: ALUControlD, flagwrite: FlagWriteD, cond: CondD};
  assign addr_d = {RA1D, RA2D, WA3D};
  assign data_d = {RD1D, RD2D, ExtImmD};

  flopenrc #(.WIDTH($bits(ctrl_t))) u_ctrl (
    .clk(clk), .reset(reset), .en_i(pipe_en), .clr_i(FlushE),
    .d_i(ctrl_d), .q_o(ctrl_q)
  );

  flopenrc #(.WIDTH(12)) u_addr (
    .clk(clk), .reset(reset), .en_i(pipe_en), .clr_i(FlushE),
    .d_i(addr_d), .q_o(addr_q)
  );

  flopenrc #(.WIDTH(3*WIDTH)) u_data (
    .clk(clk), .reset(reset), .en_i(pipe_en), .clr_i(FlushE),
    .d_i(data_d), .q_o(data_q)
  );

  flopenrc #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en_i(pipe_en), .clr_i(FlushE),
    .d_i(1'b1), .q_o(ValidE)
  );

  flopenrc #(.WIDTH(NFLAGS)) u_flags (
    .clk(clk), .reset(reset), .en_i(flags_en), .clr_i(1'b0),
    .d_i(FlagsNextE), .q_o(FlagsE)
  );

  assign PCSrcE      = ctrl_q.pcsrc;
  assign RegWriteE   = ctrl_q.regwrite;
  assign MemtoRegE   = ctrl_q.memtoreg;
  assign MemWriteE   = ctrl_q.memwrite;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alusrc;
  assign ALUControlE = ctrl_q.alucontrol;
  assign FlagWriteE  = ctrl_q.flagwrite;
  assign CondE       = ctrl_q.cond;

  assign {RA1E, RA2E, WA3E}     = addr_q;
  assign {RD1E, RD2E, ExtImmE}  = data_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, async reset sequences and
// randomized traffic against a stage-level reference model.
module tb_id_ex_pipe_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic StallE, FlushE;
  logic PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWriteD;
  logic [3:0] CondD, RA1D, RA2D, WA3D;
  logic [W-1:0] RD1D, RD2D, ExtImmD;
  logic [3:0] FlagsNextE;
  logic PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0] ALUControlE, FlagWriteE;
  logic [3:0] CondE, RA1E, RA2E, WA3E;
  logic [W-1:0] RD1E, RD2E, ExtImmE;
  logic [3:0] FlagsE;
  logic ValidE;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.WIDTH(W), .NFLAGS(4)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .FlagsNextE(FlagsNextE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .FlagsE(FlagsE),
    .ValidE(ValidE)
  );

  // Reference model: the E stage is one instruction record plus a flags word.
  typedef struct {
    logic [13:0]  ctrl;
    logic [11:0]  addr;
    logic [95:0]  data;
    logic         valid;
    logic [3:0]   flags;
  } stage_t;

  stage_t m;

  function automatic logic [13:0] d_ctrl();
    return {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
            ALUControlD, FlagWriteD, CondD};
  endfunction

  function automatic logic [13:0] e_ctrl();
    return {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
            ALUControlE, FlagWriteE, CondE};
  endfunction

  task automatic model_reset();
    m.ctrl = '0; m.addr = '0; m.data = '0; m.valid = 1'b0; m.flags = '0;
  endtask

  task automatic model_edge();
    if (FlushE) begin
      m.ctrl = '0; m.addr = '0; m.data = '0; m.valid = 1'b0;
    end else if (!StallE) begin
      m.ctrl = d_ctrl();
      m.addr = {RA1D, RA2D, WA3D};
      m.data = {RD1D, RD2D, ExtImmD};
      m.valid = 1'b1;
    end
    if (!(StallE && !FlushE)) m.flags = FlagsNextE;
  endtask

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".ctrl"},  128'(e_ctrl()), 128'(m.ctrl));
    cmp({tag, ".addr"},  128'({RA1E, RA2E, WA3E}), 128'(m.addr));
    cmp({tag, ".data"},  128'({RD1E, RD2E, ExtImmE}), 128'(m.data));
    cmp({tag, ".valid"}, 128'(ValidE), 128'(m.valid));
    cmp({tag, ".flags"}, 128'(FlagsE), 128'(m.flags));
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, ".ctrl0"},  128'(e_ctrl()), 128'(0));
    cmp({tag, ".addr0"},  128'({RA1E, RA2E, WA3E}), 128'(0));
    cmp({tag, ".data0"},  128'({RD1E, RD2E, ExtImmE}), 128'(0));
    cmp({tag, ".valid0"}, 128'(ValidE), 128'(0));
    cmp({tag, ".flags0"}, 128'(FlagsE), 128'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic randomize_d();
    {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD} = 6'($urandom);
    ALUControlD = 2'($urandom); FlagWriteD = 2'($urandom); CondD = 4'($urandom);
    RA1D = 4'($urandom); RA2D = 4'($urandom); WA3D = 4'($urandom);
    RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom;
    FlagsNextE = 4'($urandom);
  endtask

  typedef struct {
    logic         stall, flush;
    logic [W-1:0] rd1;
    logic [3:0]   cond;
    logic         rw;
    logic [3:0]   wa3;
    logic [3:0]   fnext;
    logic [W-1:0] e_rd1;
    logic [3:0]   e_cond;
    logic         e_rw;
    logic [3:0]   e_wa3;
    logic         e_valid;
    logic [3:0]   e_flags;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // stall flush rd1 cond rw wa3 fnext | rd1E condE rwE wa3E validE flagsE
    vt[0] = '{0, 0, 32'h5,        4'hE, 1, 4'd3, 4'b0000, 32'h5,  4'hE, 1, 4'd3, 1, 4'b0000};
    vt[1] = '{0, 0, 32'h7,        4'h0, 0, 4'd0, 4'b0100, 32'h7,  4'h0, 0, 4'd0, 1, 4'b0100};
    vt[2] = '{1, 0, 32'hFFFFFFFF, 4'hF, 1, 4'd9, 4'b1111, 32'h7,  4'h0, 0, 4'd0, 1, 4'b0100};
    vt[3] = '{1, 0, 32'hFFFFFFFF, 4'hF, 1, 4'd9, 4'b1111, 32'h7,  4'h0, 0, 4'd0, 1, 4'b0100};
    vt[4] = '{1, 0, 32'hFFFFFFFF, 4'hF, 1, 4'd9, 4'b1111, 32'h7,  4'h0, 0, 4'd0, 1, 4'b0100};
    vt[5] = '{0, 0, 32'h9,        4'h1, 1, 4'd5, 4'b1111, 32'h9,  4'h1, 1, 4'd5, 1, 4'b1111};
    vt[6] = '{0, 1, 32'hAA,       4'h2, 1, 4'd6, 4'b1000, 32'h0,  4'h0, 0, 4'd0, 0, 4'b1000};
    vt[7] = '{1, 1, 32'hBB,       4'h3, 1, 4'd7, 4'b0010, 32'h0,  4'h0, 0, 4'd0, 0, 4'b0010};
    vt[8] = '{1, 0, 32'hCC,       4'h5, 1, 4'd8, 4'b0001, 32'h0,  4'h0, 0, 4'd0, 0, 4'b0010};
    vt[9] = '{0, 0, 32'hDD,       4'h4, 0, 4'd2, 4'b0011, 32'hDD, 4'h4, 0, 4'd2, 1, 4'b0011};

    // Reset held with every D input at ones; outputs must stay zero.
    reset = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD} = '1;
    ALUControlD = '1; FlagWriteD = '1; CondD = '1;
    RA1D = '1; RA2D = '1; WA3D = '1; RD1D = '1; RD2D = '1; ExtImmD = '1;
    FlagsNextE = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("reset_release");
    step();
    cmp("first_edge.rd1", 128'(RD1E), 128'(32'hFFFFFFFF));
    cmp("first_edge.valid", 128'(ValidE), 128'(1));
    check_model("first_edge");

    for (int i = 0; i < 10; i++) begin
      StallE = vt[i].stall; FlushE = vt[i].flush;
      RD1D = vt[i].rd1; CondD = vt[i].cond; RegWriteD = vt[i].rw;
      {PCSrcD, MemtoRegD, MemWriteD, BranchD, ALUSrcD} = {5{vt[i].rw}};
      ALUControlD = '0; FlagWriteD = '0;
      RA1D = '0; RA2D = '0; WA3D = vt[i].wa3; RD2D = '0; ExtImmD = '0;
      FlagsNextE = vt[i].fnext;
      step();
      cmp($sformatf("vec%0d.rd1", i), 128'(RD1E), 128'(vt[i].e_rd1));
      cmp($sformatf("vec%0d.cond", i), 128'(CondE), 128'(vt[i].e_cond));
      cmp($sformatf("vec%0d.ctrl", i),
          128'({PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE}),
          128'({6{vt[i].e_rw}}));
      cmp($sformatf("vec%0d.wa3", i), 128'(WA3E), 128'(vt[i].e_wa3));
      cmp($sformatf("vec%0d.valid", i), 128'(ValidE), 128'(vt[i].e_valid));
      cmp($sformatf("vec%0d.flags", i), 128'(FlagsE), 128'(vt[i].e_flags));
      check_model($sformatf("vec%0d", i));
      $display("vec %0d stall=%0b flush=%0b rd1E=%h validE=%0b flagsE=%b",
               i, StallE, FlushE, RD1E, ValidE, FlagsE);
    end

    // Randomized traffic with stall/flush each roughly a quarter of the time.
    for (int i = 0; i < 300; i++) begin
      randomize_d();
      StallE = ($urandom_range(3) == 0);
      FlushE = ($urandom_range(3) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
      $display("rnd %0d stall=%0b flush=%0b validE=%0b flagsE=%b",
               i, StallE, FlushE, ValidE, FlagsE);
    end

    // Asynchronous reset between edges with a live instruction and flags 0110.
    randomize_d();
    StallE = 1'b0; FlushE = 1'b0; FlagsNextE = 4'b0110;
    step();
    cmp("pre_async.valid", 128'(ValidE), 128'(1));
    cmp("pre_async.flags", 128'(FlagsE), 128'(4'b0110));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    StallE = 1'b1; FlushE = 1'b1;
    #3;
    reset = 1'b1;
    randomize_d();
    StallE = 1'b1; FlushE = 1'b0;
    step();
    check_model("post_reset_stall");
    for (int i = 0; i < 20; i++) begin
      randomize_d();
      StallE = ($urandom_range(2) == 0);
      FlushE = ($urandom_range(4) == 0);
      step();
      check_model($sformatf("tail%0d", i));
      $display("tail %0d stall=%0b flush=%0b validE=%0b flagsE=%b",
               i, StallE, FlushE, ValidE, FlagsE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-Execute pipeline register for the pipelined ARM core.
- Captures Decode-stage control, register addresses and operand data each cycle and presents them as the E-stage signals consumed by the condition-check and ALU logic.
- Also holds the architectural NZCV flags register: FlagsE is driven from here and reloads from FlagsNextE, which the condition logic returns.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- WIDTH, 32, datapath width of RD1, RD2 and ExtImm.
- NFLAGS, 4, flag register width, ordered {N,Z,C,V}.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- StallE  input  1  hold all E-stage state this cycle.
- FlushE  input  1  load a bubble into the E stage this cycle.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  input  1 each  Decode control bits.
- ALUControlD  input  2  ALU operation select.
- FlagWriteD  input  2  [1]=NZ write enable, [0]=CV write enable.
- CondD  input  4  condition field.
- RA1D, RA2D, WA3D  input  4 each  source and destination register numbers.
- RD1D, RD2D, ExtImmD  input  WIDTH each  operand data.
- FlagsNextE  input  NFLAGS  next flag value from the condition logic.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE  output  1 each  registered control bits.
- ALUControlE  output  2  registered ALU select.
- FlagWriteE  output  2  registered flag write enables.
- CondE  output  4  registered condition field.
- RA1E, RA2E, WA3E  output  4 each  registered register numbers, used by the forwarding unit.
- RD1E, RD2E, ExtImmE  output  WIDTH each  registered operands.
- FlagsE  output  NFLAGS  architectural flags.
- ValidE  output  1  1 = E stage holds a real instruction; 0 = bubble.

Behaviour:
- Reset (reset=0, asynchronous):
  - every output goes to 0 immediately, including FlagsE=4'b0000 and ValidE=0;
  - the pipe is empty; the state is held until reset deasserts.
- The pipeline register group is every *E output except FlagsE. On each rising clk it updates by this priority:
  1. FlushE=1: load the bubble. All control, FlagWriteE, CondE, RA/WA and data fields go to 0; ValidE=0. FlushE wins over StallE.
  2. else StallE=1: hold every field, including ValidE.
  3. else: load all D inputs; ValidE=1.
- Flags register (FlagsE), on each rising clk:
  - StallE=1 and FlushE=0: hold. The stalled instruction stays in E, and its condition must re-evaluate against the same flags.
  - otherwise: FlagsE <= FlagsNextE.
  - Because FlagsNextE is evaluated against the instruction currently in E, a flush of E does not discard the flag update of the instruction leaving E.
  - A bubble has FlagWriteE=0, so FlagsNextE equals FlagsE; loading it is a no-op.
- Latency: one cycle D->E for every field; FlagsNextE->FlagsE is one cycle.
- No combinational path from any input to any output.
- Reset mid-stall or mid-flush: reset dominates asynchronously. The first edge after release follows the normal priority.
- X on D inputs during a flush or stall edge must not reach the outputs.

Decomposition:
- Shared package `arm_pipe_pkg`:
  - constant NFLAGS=4;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the bubble control encoding (all-zero), named CTRL_BUBBLE.
- Sub-module `flopenrc`: parameterised WIDTH flip-flop with async active-low reset, enable and synchronous clear. Instantiate it once per field group (control, addresses, data, valid).
- FlagsE uses `flopenrc` with enable = ~StallE | FlushE and clear tied to 0.

Test Plan:
- Reset: hold reset=0 with all D inputs = 1s, then release -> all outputs 0 before the first edge. On the next edge with StallE=FlushE=0, RD1E=RD1D and ValidE=1.
- Normal flow: RD1D=32'h0000_0005, CondD=4'hE, RegWriteD=1, WA3D=4'd3 -> exactly one cycle later RD1E=5, CondE=4'hE, RegWriteE=1, WA3E=3, ValidE=1.
- Stall: load an instruction, then StallE=1 for 3 cycles while D inputs change to RD1D=32'hFFFF_FFFF and FlagsNextE=4'b1111 -> E outputs and FlagsE stay frozen at their pre-stall values. The cycle after StallE drops, both update.
- Flush: FlushE=1 with RegWriteD=MemWriteD=BranchD=1 -> next cycle all control bits 0, ValidE=0, RD1E=0. With FlagsE=4'b0100 and FlagsNextE=4'b1000 in the same cycle, FlagsE becomes 4'b1000.
- Flush+stall together: FlushE=1 and StallE=1 -> bubble loaded, ValidE=0, FlagsE updated from FlagsNextE (flush priority).
- Async reset mid-operation: assert reset=0 between edges while ValidE=1 and FlagsE=4'b0110 -> outputs go to 0 without waiting for clk.
